e_stage: RTL and testbench
==========================

Name: e_stage

Overview:
- Execute stage of the five-stage RV32 pipeline. Sits between decode and the memory stage.
- Computes the ALU result from decoded operands and registers it for the memory stage. Also registers pc, the 7-bit memory-control bundle and the 6-bit writeback-control bundle alongside it.
- Contains an iterative divider for DIV/DIVU/REM/REMU. While the divider is busy, the stage stalls upstream and emits bubbles downstream.

Parameters:
- XLEN, 32, datapath width. Divider iteration count equals XLEN.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode presents a valid instruction
- alu_op  in  5  operation code (encodings in e_pkg)
- op_a  in  XLEN  operand A (rs1 or pc)
- op_b  in  XLEN  operand B (rs2 or immediate)
- pc_in  in  32  instruction pc
- m_con_in  in  7  memory-stage control: [1:0] wb select, [3:2] read enable, [5:4] write enable, [6] sign
- w_con_in  in  6  writeback control, passed through
- stall  out  1  combinational; decode must hold all inputs while high
- out_valid  out  1  registered; result bundle valid
- alu_result  out  XLEN  registered result, also the data address
- pc_out  out  32  registered pc
- m_con_out  out  7  registered memory control
- w_con_out  out  6  registered writeback control

Behaviour:
- Reset: all outputs are 0, the FSM is IDLE and the divider state is cleared. Reset asserted mid-division aborts the division; no result is ever emitted for it.
- Ops:
  - ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B.
  - MUL (low 32 bits of the product).
  - DIV, DIVU, REM, REMU.
  - Shift amount is op_b[4:0]. Arithmetic wraps modulo 2^32.
  - An undefined op produces result 0, with the control bundles passed through unchanged.
- Single-cycle ops: when in_valid=1 in IDLE, the result and the pc/m_con/w_con bundles are registered at the next edge with out_valid=1. Latency is 1 cycle and stall=0.
- Bubble: when in_valid=0 in IDLE, the next edge registers out_valid=0, m_con_out=0 and w_con_out=0. alu_result and pc_out hold their previous values.
- FSM:
  - States are IDLE and BUSY. BUSY has a count register of 6 bits.
  - IDLE -> BUSY: in_valid=1 and the op is a non-special divide. At that edge the operands are captured (signed ops take absolute values and record the result sign) and count=XLEN.
  - In BUSY, each edge performs one restoring-division step and decrements count. The edge where count goes from 1 to 0 registers the final result, sets out_valid=1, registers the captured control bundles and returns to IDLE.
  - In BUSY, in_valid and all inputs are ignored.
- Stall: stall = (IDLE & in_valid & non-special divide) | (BUSY & count!=1).
  - Stall drops in the last BUSY cycle so decode advances on the same edge the result is emitted.
  - A divide therefore occupies XLEN+1 cycles.
  - Edges taken while BUSY (other than the final one) emit bubbles: out_valid=0 and zeroed control.
- Special divides complete in one cycle, with no stall and the divider unused:
  - Divisor 0: quotient is all ones; remainder is the dividend.
  - DIV/REM with -2^31 / -1: quotient is -2^31; remainder is 0.
- Sign fix-up:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Back-to-back divides: the second divide is accepted in the IDLE cycle right after the first result, with no extra gap.

Optional Feature:
- Macro: E_STAGE_M_EXT_EN.
- Defined: MUL and all divide ops are implemented as described above.
- Undefined:
  - MUL and all divide ops decode as undefined ops: result 0, 1-cycle latency.
  - stall is tied to 0.
  - The divider and FSM are not instantiated.

Decomposition:
- Package e_pkg holds:
  - the alu_op encoding constants;
  - the FSM state typedef;
  - M_CON_W=7 and W_CON_W=6;
  - field indices of m_con.
- One sub-module, e_divider. It contains the iterative unsigned restoring divider with start/busy/done signals, the count register and the quotient/remainder registers. Sign handling and special cases stay in e_stage.

Test Plan:
- ADD 5+7, then SUB 3-5, back-to-back -> alu_result 12 then 0xFFFFFFFE on consecutive cycles; out_valid 1; stall never asserted.
- SRA 0x80000000 by 4; SLTU 1<2 -> results 0xF8000000 and 1.
- DIV -7/2 with w_con_in=0x25:
  - stall high for 32 cycles, then low for 1 cycle;
  - out_valid=1 exactly at edge 33 after acceptance, with alu_result 0xFFFFFFFD and w_con_out 0x25;
  - intervening outputs are bubbles with w_con_out 0.
- REM 7/0 -> result 7 after 1 cycle, no stall. DIV 0x80000000/0xFFFFFFFF -> result 0x80000000 after 1 cycle.
- rst_n pulsed low at cycle 10 of a DIVU -> outputs 0 immediately, FSM IDLE, no late result. A following ADD 1+1 yields 2.
- E_STAGE_M_EXT_EN undefined: DIV 8/2 -> result 0, 1 cycle, stall 0.

Source files
------------

// File: rtl/e_pkg.sv
// ---------------------------------------------------------------------------
// e_pkg: shared definitions for the RV32 execute stage.
//   - alu_op encodings (5-bit; codes 16..31 are undefined and produce 0)
//   - control bundle widths and m_con field positions
//   - execute-stage FSM state type
// Optional feature macro used by the importers: E_STAGE_M_EXT_EN.
// ---------------------------------------------------------------------------
package e_pkg;

    localparam int M_CON_W = 7;
    localparam int W_CON_W = 6;

    // m_con field positions: [1:0] wb select, [3:2] read enable,
    // [5:4] write enable, [6] load sign
    localparam int M_WB_LSB   = 0;
    localparam int M_RD_LSB   = 2;
    localparam int M_WR_LSB   = 4;
    localparam int M_SIGN_BIT = 6;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_PASS_B = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd11;
    localparam logic [4:0] OP_DIV    = 5'd12;
    localparam logic [4:0] OP_DIVU   = 5'd13;
    localparam logic [4:0] OP_REM    = 5'd14;
    localparam logic [4:0] OP_REMU   = 5'd15;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } e_state_t;

endpackage

// File: rtl/e_divider.sv
// ---------------------------------------------------------------------------
// e_divider: iterative unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n          clock / async active-low reset (clears count)
//   start               load dividend/divisor and begin XLEN steps
//   dividend, divisor   unsigned operands (divisor must be non-zero)
//   busy                steps remain (count != 0)
//   last                current cycle performs the final step (count == 1)
//   quotient, remainder result of the step taken in the current cycle; equal
//                       to the final answer while last is high
// ---------------------------------------------------------------------------
module e_divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            last,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    logic [5:0]      count;
    logic [XLEN-1:0] q_r;   // dividend bits shift out the top, quotient bits in the bottom
    logic [XLEN-1:0] r_r;
    logic [XLEN-1:0] d_r;
    logic [XLEN:0]   r_sh;
    logic            fits;

    assign r_sh      = {r_r, q_r[XLEN-1]};
    assign fits      = r_sh >= {1'b0, d_r};
    assign quotient  = {q_r[XLEN-2:0], fits};
    // the partial remainder is always below the divisor, so XLEN bits suffice
    assign remainder = fits ? XLEN'(r_sh - {1'b0, d_r}) : r_sh[XLEN-1:0];

    assign busy = count != 6'd0;
    assign last = count == 6'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            q_r   <= '0;
            r_r   <= '0;
            d_r   <= '0;
        end else if (start) begin
            count <= 6'(XLEN);
            q_r   <= dividend;
            r_r   <= '0;
            d_r   <= divisor;
        end else if (busy) begin
            count <= count - 6'd1;
            q_r   <= quotient;
            r_r   <= remainder;
        end
    end

endmodule

// File: rtl/e_stage.sv
// ---------------------------------------------------------------------------
// e_stage: RV32 execute stage. Computes the ALU result and registers it with
// pc and the memory/writeback control bundles for the memory stage.
//   clk, rst_n       clock / async active-low reset
//   in_valid         decode presents an instruction
//   alu_op, op_a/b   operation and operands (encodings in e_pkg)
//   pc_in, m_con_in, w_con_in   side-band carried with the result
//   stall            combinational; decode holds inputs while high
//   out_valid, alu_result, pc_out, m_con_out, w_con_out   registered outputs
// Macro E_STAGE_M_EXT_EN: when defined, adds MUL and an iterative divider
// for DIV/DIVU/REM/REMU (XLEN+1 cycles, stalling decode). When undefined,
// those ops produce 0 in one cycle and stall is constant 0.
// ---------------------------------------------------------------------------
module e_stage
    import e_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [4:0]         alu_op,
    input  logic [XLEN-1:0]    op_a,
    input  logic [XLEN-1:0]    op_b,
    input  logic [31:0]        pc_in,
    input  logic [M_CON_W-1:0] m_con_in,
    input  logic [W_CON_W-1:0] w_con_in,
    output logic               stall,
    output logic               out_valid,
    output logic [XLEN-1:0]    alu_result,
    output logic [31:0]        pc_out,
    output logic [M_CON_W-1:0] m_con_out,
    output logic [W_CON_W-1:0] w_con_out
);

    logic [XLEN-1:0] alu_res;
    logic [4:0]      shamt;

    assign shamt = op_b[4:0];

`ifdef E_STAGE_M_EXT_EN
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    e_state_t           state;
    logic               div_op, div_signed, div_by_zero, div_ovf, div_start;
    logic               a_neg, b_neg;
    logic [XLEN-1:0]    abs_a, abs_b;
    logic               dv_busy, dv_last;
    logic [XLEN-1:0]    dv_quo, dv_rem, dv_mag, div_final;
    logic               cap_neg, cap_rem;
    logic [31:0]        cap_pc;
    logic [M_CON_W-1:0] cap_m;
    logic [W_CON_W-1:0] cap_w;

    assign div_op      = alu_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign div_signed  = (alu_op == OP_DIV) || (alu_op == OP_REM);
    assign div_by_zero = op_b == '0;
    assign div_ovf     = div_signed && (op_a == SMIN) && (op_b == '1);
    // special divides resolve in the ALU; only the rest use the divider
    assign div_start   = (state == S_IDLE) && in_valid && div_op && !div_by_zero && !div_ovf;

    assign a_neg = div_signed && op_a[XLEN-1];
    assign b_neg = div_signed && op_b[XLEN-1];
    assign abs_a = a_neg ? -op_a : op_a;
    assign abs_b = b_neg ? -op_b : op_b;

    // release decode in the final busy cycle so it advances as the result lands
    assign stall = div_start || (dv_busy && !dv_last);

    e_divider #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .busy      (dv_busy),
        .last      (dv_last),
        .quotient  (dv_quo),
        .remainder (dv_rem)
    );

    assign dv_mag    = cap_rem ? dv_rem : dv_quo;
    assign div_final = cap_neg ? -dv_mag : dv_mag;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:    alu_res = op_a + op_b;
            OP_SUB:    alu_res = op_a - op_b;
            OP_SLL:    alu_res = op_a << shamt;
            OP_SLT:    alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_SLTU:   alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            OP_XOR:    alu_res = op_a ^ op_b;
            OP_SRL:    alu_res = op_a >> shamt;
            OP_SRA:    alu_res = $signed(op_a) >>> shamt;
            OP_OR:     alu_res = op_a | op_b;
            OP_AND:    alu_res = op_a & op_b;
            OP_PASS_B: alu_res = op_b;
`ifdef E_STAGE_M_EXT_EN
            OP_MUL:    alu_res = op_a * op_b;
            // only special cases are taken from here: /0 or signed overflow
            OP_DIV, OP_DIVU: alu_res = div_by_zero ? '1 : SMIN;
            OP_REM, OP_REMU: alu_res = div_by_zero ? op_a : '0;
`endif
            default:   alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            alu_result <= '0;
            pc_out     <= '0;
            m_con_out  <= '0;
            w_con_out  <= '0;
`ifdef E_STAGE_M_EXT_EN
            state      <= S_IDLE;
            cap_neg    <= 1'b0;
            cap_rem    <= 1'b0;
            cap_pc     <= '0;
            cap_m      <= '0;
            cap_w      <= '0;
`endif
        end else begin
            // bubble unless overridden; alu_result and pc_out hold
            out_valid <= 1'b0;
            m_con_out <= '0;
            w_con_out <= '0;
`ifdef E_STAGE_M_EXT_EN
            if (state == S_BUSY) begin
                if (dv_last) begin
                    out_valid  <= 1'b1;
                    alu_result <= div_final;
                    pc_out     <= cap_pc;
                    m_con_out  <= cap_m;
                    w_con_out  <= cap_w;
                    state      <= S_IDLE;
                end
            end else if (div_start) begin
                state   <= S_BUSY;
                cap_rem <= (alu_op == OP_REM) || (alu_op == OP_REMU);
                // remainder follows the dividend sign, quotient the sign xor
                cap_neg <= (alu_op == OP_REM) ? a_neg : (a_neg ^ b_neg);
                cap_pc  <= pc_in;
                cap_m   <= m_con_in;
                cap_w   <= w_con_in;
            end else
`endif
            if (in_valid) begin
                out_valid  <= 1'b1;
                alu_result <= alu_res;
                pc_out     <= pc_in;
                m_con_out  <= m_con_in;
                w_con_out  <= w_con_in;
            end
        end
    end

endmodule

// File: tb/tb_e_stage.sv
// ---------------------------------------------------------------------------
// tb_e_stage: directed bench for e_stage. Expected results are queued when an
// instruction is driven and popped when out_valid rises. Divide tests are
// compiled only with E_STAGE_M_EXT_EN; otherwise M ops are checked as 0.
// ---------------------------------------------------------------------------
module tb_e_stage;
    import e_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [4:0]  alu_op = '0;
    logic [31:0] op_a = '0, op_b = '0, pc_in = '0;
    logic [6:0]  m_con_in = '0;
    logic [5:0]  w_con_in = '0;
    logic        stall, out_valid;
    logic [31:0] alu_result, pc_out;
    logic [6:0]  m_con_out;
    logic [5:0]  w_con_out;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] pc;
        logic [6:0]  m;
        logic [5:0]  w;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    e_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_op(alu_op),
        .op_a(op_a), .op_b(op_b), .pc_in(pc_in), .m_con_in(m_con_in),
        .w_con_in(w_con_in), .stall(stall), .out_valid(out_valid),
        .alu_result(alu_result), .pc_out(pc_out), .m_con_out(m_con_out),
        .w_con_out(w_con_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        if (out_valid === 1'b1) begin
            chk("valid_has_expectation", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", alu_result, e.res);
                chk("pc_out", pc_out, e.pc);
                chk("m_con_out", 32'(m_con_out), 32'(e.m));
                chk("w_con_out", 32'(w_con_out), 32'(e.w));
            end
        end else begin
            chk("bubble_m_con", 32'(m_con_out), 32'd0);
            chk("bubble_w_con", 32'(w_con_out), 32'd0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic set_in(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pc, input logic [6:0] m, input logic [5:0] w);
        alu_op = op; op_a = a; op_b = b; pc_in = pc; m_con_in = m; w_con_in = w;
        in_valid = 1'b1;
    endtask

    // single-cycle instruction: no stall, result on the next edge
    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [6:0] m, input logic [5:0] w,
                         input logic [31:0] exp);
        exp_t e;
        set_in(op, a, b, pc, m, w);
        #1;
        chk("stall_single_cycle", 32'(stall), 32'd0);
        e.res = exp; e.pc = pc; e.m = m; e.w = w;
        sb.push_back(e);
        tick();
        chk("valid_single_cycle", 32'(out_valid), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

`ifdef E_STAGE_M_EXT_EN
    // multi-cycle divide: counts stall cycles and edges until out_valid
    task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [6:0] m, input logic [5:0] w,
                           input logic [31:0] exp);
        exp_t e;
        int   edges = 0;
        int   hi = 0;
        set_in(op, a, b, pc, m, w);
        e.res = exp; e.pc = pc; e.m = m; e.w = w;
        sb.push_back(e);
        while (edges < 40) begin
            #1;
            if (stall === 1'b1) hi++;
            tick();
            edges++;
            if (out_valid === 1'b1) break;
        end
        chk("div_edges_to_result", 32'(edges), 32'd33);
        chk("div_stall_cycles", 32'(hi), 32'd32);
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        // reset state
        @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_result", alu_result, 32'd0);
        chk("rst_pc_out", pc_out, 32'd0);
        chk("rst_m_con", 32'(m_con_out), 32'd0);
        chk("rst_w_con", 32'(w_con_out), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst_n = 1'b1;

        // back-to-back single-cycle ops
        drive(OP_ADD, 32'd5, 32'd7, 32'h100, 7'h15, 6'h11, 32'd12);
        drive(OP_SUB, 32'd3, 32'd5, 32'h104, 7'h2A, 6'h22, 32'hFFFF_FFFE);
        idle(1);
        chk("bubble_holds_result", alu_result, 32'hFFFF_FFFE);
        chk("bubble_holds_pc", pc_out, 32'h104);
        chk("bubble_out_valid", 32'(out_valid), 32'd0);

        drive(OP_SRA,    32'h8000_0000, 32'd4,         32'h108, 7'h01, 6'h01, 32'hF800_0000);
        drive(OP_SLTU,   32'd1,         32'd2,         32'h10C, 7'h02, 6'h02, 32'd1);
        drive(OP_SLTU,   32'hFFFF_FFFF, 32'd1,         32'h110, 7'h03, 6'h03, 32'd0);
        drive(OP_SLT,    32'hFFFF_FFFF, 32'd1,         32'h114, 7'h04, 6'h04, 32'd1);
        drive(OP_SLL,    32'd3,         32'h24,        32'h118, 7'h05, 6'h05, 32'h30);
        drive(OP_SRL,    32'h8000_0000, 32'd4,         32'h11C, 7'h06, 6'h06, 32'h0800_0000);
        drive(OP_XOR,    32'hF0F0,      32'hFF00,      32'h120, 7'h07, 6'h07, 32'h0FF0);
        drive(OP_OR,     32'hF000,      32'h000F,      32'h124, 7'h08, 6'h08, 32'hF00F);
        drive(OP_AND,    32'hFF0F,      32'h0FF0,      32'h128, 7'h09, 6'h09, 32'h0F00);
        drive(OP_PASS_B, 32'd1,         32'hDEAD_BEEF, 32'h12C, 7'h0A, 6'h0A, 32'hDEAD_BEEF);
        drive(OP_ADD,    32'hFFFF_FFFF, 32'd1,         32'h130, 7'h0B, 6'h0B, 32'd0);
        drive(5'd31,     32'd9,         32'd9,         32'h134, 7'h7F, 6'h3F, 32'd0);
        idle(1);

`ifdef E_STAGE_M_EXT_EN
        drive(OP_MUL, 32'h1234_5678, 32'h10, 32'h200, 7'h11, 6'h11, 32'h2345_6780);
        drive(OP_MUL, 32'd3, 32'hFFFF_FFFC, 32'h204, 7'h12, 6'h12, 32'hFFFF_FFF4);
        idle(1);

        run_div(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'h300, 7'h13, 6'h25, 32'hFFFF_FFFD);
        idle(2);
        // second divide accepted in the cycle right after the first result
        run_div(OP_DIVU, 32'd100, 32'd7, 32'h304, 7'h14, 6'h14, 32'd14);
        run_div(OP_REMU, 32'd100, 32'd7, 32'h308, 7'h15, 6'h15, 32'd2);
        run_div(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'h30C, 7'h16, 6'h16, 32'hFFFF_FFFF);
        run_div(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h310, 7'h17, 6'h17, 32'hFFFF_FFFD);
        run_div(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'h314, 7'h18, 6'h18, 32'hFFFF_FFFF);

        // special divides: one cycle, no stall
        drive(OP_REM,  32'd7,         32'd0,         32'h400, 7'h19, 6'h19, 32'd7);
        drive(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h404, 7'h1A, 6'h1A, 32'h8000_0000);
        drive(OP_DIVU, 32'd5,         32'd0,         32'h408, 7'h1B, 6'h1B, 32'hFFFF_FFFF);
        drive(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h40C, 7'h1C, 6'h1C, 32'd0);
        idle(1);

        // reset in the middle of a divide aborts it
        set_in(OP_DIVU, 32'd1000, 32'd3, 32'h500, 7'h1D, 6'h1D);
        #1;
        chk("divu_accept_stall", 32'(stall), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_alu_result", alu_result, 32'd0);
        chk("midrst_pc_out", pc_out, 32'd0);
        chk("midrst_m_con", 32'(m_con_out), 32'd0);
        chk("midrst_w_con", 32'(w_con_out), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        tick();
        rst_n = 1'b1;
        idle(40);
        drive(OP_ADD, 32'd1, 32'd1, 32'h600, 7'h1E, 6'h1E, 32'd2);
`else
        // M ops decode as undefined: result 0 in one cycle, no stall
        drive(OP_DIV, 32'd8, 32'd2, 32'h200, 7'h11, 6'h11, 32'd0);
        drive(OP_MUL, 32'd3, 32'd4, 32'h204, 7'h12, 6'h12, 32'd0);
        drive(OP_REMU, 32'd9, 32'd4, 32'h208, 7'h13, 6'h13, 32'd0);
`endif
        idle(2);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
